// File: rtl/rep_window_monitor.sv
// Trigger/event repetition checker: counts qualified events in a bounded
// window opened by a rising trigger, flags the goto point and the verdict.
module rep_window_monitor #(
    parameter int MIN_CNT = 3,
    parameter int MAX_CNT = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             evt,
    input  logic             win,
    output logic             busy,
    output logic             goto_hit,
    output logic             nc_pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             retrig_err
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_e;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_UNDER = 2'd1;
    localparam logic [1:0] FC_OVER  = 2'd2;
    localparam logic [1:0] FC_WIN   = 2'd3;

    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             trig_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [1:0]       code_q, code_d;
    logic             goto_q, goto_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             retrig_q, retrig_d;

    logic             rose;
    logic             active;
    logic             done;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_sel;
    logic [CNT_W-1:0] k;

    assign rose = trig & ~trig_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        code_d   = code_q;
        goto_d   = 1'b0;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        retrig_d = 1'b0;
        done     = 1'b0;
        active   = (state_q == COUNT) | rose;
        base_cnt = (state_q == IDLE) ? '0 : cnt_q;
        k        = (state_q == IDLE) ? '0 : tmr_q;
        cnt_nxt  = base_cnt + 1'b1;
        cnt_sel  = base_cnt;

        if (active) begin
            if (state_q == IDLE) begin
                code_d = FC_NONE;
            end
            if (!win) begin
                fail_d = 1'b1;
                code_d = FC_WIN;
                done   = 1'b1;
            end else begin
                if (evt) begin
                    cnt_sel = cnt_nxt;
                    goto_d  = (cnt_nxt == MIN_V);
                    if (cnt_nxt > MAX_V) begin
                        fail_d = 1'b1;
                        code_d = FC_OVER;
                        done   = 1'b1;
                    end
                end
                // Close verdict still applies when the goto event lands here.
                if (!done && k == LAST_V) begin
                    done = 1'b1;
                    if (cnt_sel >= MIN_V) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        code_d = FC_UNDER;
                    end
                end
            end
            cnt_d = cnt_sel;
            if (done) begin
                state_d = IDLE;
                tmr_d   = '0;
            end else begin
                state_d = COUNT;
                tmr_d   = k + 1'b1;
            end
            retrig_d = (state_q == COUNT) & rose & ~done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trig_q   <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            code_q   <= FC_NONE;
            goto_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            retrig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            code_q   <= code_d;
            goto_q   <= goto_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            retrig_q <= retrig_d;
        end
    end

    assign busy       = (state_q == COUNT);
    assign goto_hit   = goto_q;
    assign nc_pass    = pass_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign evt_cnt    = cnt_q;
    assign retrig_err = retrig_q;

endmodule

// File: tb/tb_rep_window_monitor.sv
// Directed bench for rep_window_monitor with MIN=3, MAX=5, TIMEOUT=16.
module tb_rep_window_monitor;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic       evt;
    logic       win;
    logic       busy;
    logic       goto_hit;
    logic       nc_pass;
    logic       fail;
    logic [1:0] fail_code;
    logic [7:0] evt_cnt;
    logic       retrig_err;

    int n_cmp = 0;
    int n_bad = 0;

    rep_window_monitor #(
        .MIN_CNT(3),
        .MAX_CNT(5),
        .TIMEOUT(16),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .evt       (evt),
        .win       (win),
        .busy      (busy),
        .goto_hit  (goto_hit),
        .nc_pass   (nc_pass),
        .fail      (fail),
        .fail_code (fail_code),
        .evt_cnt   (evt_cnt),
        .retrig_err(retrig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/goto"}, goto_hit, 0);
        chk({tag, "/pass"}, nc_pass, 0);
        chk({tag, "/fail"}, fail, 0);
        chk({tag, "/code"}, fail_code, 0);
        chk({tag, "/cnt"}, evt_cnt, 0);
        chk({tag, "/retrig"}, retrig_err, 0);
    endtask

    task automatic step(input logic t, input logic e, input logic w);
        trig = t;
        evt  = e;
        win  = w;
        @(posedge clk);
        #1;
    endtask

    // Edge 0 is the trigger edge; -1 means "never" for edge arguments.
    task automatic run_win(input string tag, input logic [15:0] em,
                           input int wlow, input int rtg, input int eg,
                           input int ev, input logic ispass,
                           input logic [1:0] ecode, input int ecnt);
        for (int k = 0; k < 19; k++) begin
            trig = (k == 0) || (k == rtg);
            evt  = (k < 16) ? em[k] : 1'b0;
            win  = (k != wlow);
            @(posedge clk);
            #1;
            chk({tag, "/goto"}, goto_hit, k == eg);
            chk({tag, "/pass"}, nc_pass, (k == ev) && ispass);
            chk({tag, "/fail"}, fail, (k == ev) && !ispass);
            chk({tag, "/busy"}, busy, k < ev);
            chk({tag, "/retrig"}, retrig_err, k == rtg);
            if (k == ev || k == 18) begin
                chk({tag, "/cnt"}, evt_cnt, ecnt);
                chk({tag, "/code"}, fail_code, ecode);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        trig  = 1'b0;
        evt   = 1'b0;
        win   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        step(0, 0, 1);
        chk_idle("idle");

        run_win("consec", 16'h000E, -1, -1, 3, 15, 1'b1, 2'd0, 3);
        step(0, 0, 1);
        run_win("noncon", 16'h1084, -1, -1, 12, 15, 1'b1, 2'd0, 3);
        step(0, 0, 1);
        run_win("over", 16'h003F, -1, -1, 2, 5, 1'b0, 2'd2, 6);
        step(0, 0, 1);
        run_win("under", 16'h0210, -1, -1, -1, 15, 1'b0, 2'd1, 2);
        step(0, 0, 1);
        run_win("winlow", 16'h0022, 5, -1, -1, 5, 1'b0, 2'd3, 1);
        step(0, 0, 1);
        run_win("retrig", 16'h000E, -1, 6, 3, 15, 1'b1, 2'd0, 3);
        step(0, 0, 1);
        run_win("lastgoto", 16'hE000, -1, -1, 15, 15, 1'b1, 2'd0, 3);
        step(0, 0, 1);

        // Reset asserted mid-window aborts without any verdict.
        step(1, 0, 1);
        step(0, 1, 1);
        for (int k = 2; k < 8; k++) step(0, 0, 1);
        chk("abort/busy_pre", busy, 1);
        chk("abort/cnt_pre", evt_cnt, 1);
        rst_n = 1'b0;
        #2;
        chk_idle("abort");
        repeat (2) @(posedge clk);
        #1;
        chk_idle("abort_hold");
        rst_n = 1'b1;
        step(0, 0, 1);
        chk_idle("post_rst");

        run_win("after_rst", 16'h000E, -1, -1, 3, 15, 1'b1, 2'd0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rep_window_monitor.md
Name: rep_window_monitor

Overview:
Synthesizable run-time checker for the trigger/event repetition rule "on a rising trigger, the event must occur between MIN_CNT and MAX_CNT times, not necessarily consecutively, while a qualifier stays high, within a bounded window".
- Reports the goto-style point, i.e. the cycle of the MIN_CNT-th event.
- Reports the non-consecutive verdict at window close.
- Sits downstream of the stimulus/DUT signals it watches and feeds the status/interrupt aggregation logic.
- Single-thread: one window is evaluated at a time.

Parameters:
- MIN_CNT, 3: minimum event count for pass; also the goto hit count. Legal range: 1 <= MIN_CNT <= MAX_CNT.
- MAX_CNT, 5: maximum event count allowed. Must satisfy MAX_CNT < 2**CNT_W - 1.
- TIMEOUT, 16: window length in clock cycles, trigger cycle included; must be >= 1.
- CNT_W, 8: width of the event counter and of the window timer; 2**CNT_W must exceed TIMEOUT.

Ports:
- clk  input  1  sampling clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- trig  input  1  trigger level; its rising edge opens a window.
- evt  input  1  event; counts once per sampled-high cycle.
- win  input  1  qualifier; must be high on every cycle of an open window.
- busy  output  1  window open.
- goto_hit  output  1  one-cycle pulse: MIN_CNT-th qualified event sampled.
- nc_pass  output  1  one-cycle pulse: window closed with count in [MIN_CNT:MAX_CNT].
- fail  output  1  one-cycle pulse: window failed.
- fail_code  output  2  0 none, 1 UNDER, 2 OVER, 3 WIN; held until the next trigger.
- evt_cnt  output  CNT_W  running/final qualified event count; held until the next trigger.
- retrig_err  output  1  one-cycle pulse: trigger rose while busy.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, all outputs 0, trig history register 0. Asserting rst_n low mid-window aborts the window with no verdict pulse.
- Edge detect: rose = trig & ~trig_q, where trig_q is trig registered every cycle.
  - A trigger held high from reset release counts as a rose on the first edge.
- All outputs are registered. A pulse is visible for exactly one cycle, starting after the edge that sampled the deciding inputs.
- FSM states: IDLE, COUNT.
- IDLE:
  - On rose, this edge is window cycle 0. Clear fail_code. Evaluate cycle 0 exactly like a COUNT cycle, so an overlapping evt counts.
  - Enter COUNT unless cycle 0 already produced a verdict.
- COUNT, per sampled edge k (window cycle k, timer = k):
  - If win == 0: fail, fail_code = WIN, go to IDLE. Any evt on this cycle is not counted.
  - Else if evt: cnt_next = evt_cnt + 1.
    - If cnt_next == MIN_CNT: pulse goto_hit.
    - If cnt_next > MAX_CNT: fail, fail_code = OVER, go to IDLE. The window aborts early without waiting for timeout.
  - Else if k == TIMEOUT-1 (window close):
    - cnt_next >= MIN_CNT: pulse nc_pass.
    - Otherwise: fail, fail_code = UNDER.
    - Go to IDLE in either case.
- Precedence within one cycle: WIN > OVER > close verdict.
  - goto_hit and nc_pass can pulse on the same cycle, e.g. the MIN_CNT-th event lands on the last window cycle.
  - goto_hit and an OVER fail can never share a cycle.
- With MIN_CNT == MAX_CNT, the next event after the goto point fails OVER.
- busy = 1 in COUNT, including the cycle after rose; it drops with the verdict pulse.
- rose while in COUNT: pulse retrig_err; count, timer and state are unaffected.
- rose on the same edge that produces a verdict is ignored. It is not re-armed and no retrig_err is raised.
- The counter saturates at MAX_CNT+1 and never wraps. The timer never exceeds TIMEOUT-1.

Test Plan (MIN_CNT=3, MAX_CNT=5, TIMEOUT=16; edge 0 = trigger edge, win=1 unless stated):
- evt high edges 1-3 (consecutive) -> goto_hit after edge 3; nc_pass after edge 15; evt_cnt=3; fail_code=0; busy low after edge 15.
- evt high edges 2, 7, 12 (non-consecutive) -> goto_hit after edge 12; nc_pass after edge 15; evt_cnt=3.
- evt high edges 0-5 -> goto_hit after edge 2; fail, fail_code=2 after edge 5; evt_cnt=6; busy drops then.
- evt high edges 4, 9 only -> no goto_hit; fail, fail_code=1 after edge 15; evt_cnt=2.
- evt edge 1, win low at edge 5 with evt high -> fail, fail_code=3 after edge 5; evt_cnt=1.
- trig re-rises at edge 6 -> retrig_err pulse, verdict unchanged.
- rst_n low at edge 8 -> all outputs 0 at once, no verdict.
- New rose after release -> normal window.
